opora_loader: RTL and testbench

Ethernet-side writer of the reference waveform (opora) consumed by the convolution core. It parses opora command frames from the UDP payload byte stream in the clke domain and buffers the 200 words. After the frame checksum passes, it replays the words as a gap-free opora_en/OPORA burst of exactly NUM_OPORA strobes. Bad or foreign frames never reach the convolution core.

---
 rtl/opora_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_opora_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opora_loader.sv
// opora_loader: parses opora command frames from the UDP payload stream,
// buffers the NUM_OPORA words and replays them as a gap-free strobe burst
// once the frame checksum has been accepted.
module opora_loader (
  input  logic        clke,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        opora_en,
  output logic [15:0] OPORA,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code
);

  localparam int unsigned NUM_OPORA = 200;
  localparam int unsigned GAP       = 2;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned GAP_W     = 2;
  localparam int unsigned WORD_W    = 16;
  localparam logic [7:0]  CMD_OPORA = 8'hA5;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPORA - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP);

  localparam logic [1:0] ERR_BUSY  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DROP,
    S_PLAY,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       csum, csum_nxt;
  logic [7:0]       hi_byte, hi_nxt;
  logic             lo_phase, phase_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             drop_pend, pend_nxt;
  logic [1:0]       err_code_nxt;
  logic             err_c;
  logic             wr_c;
  logic             rd_c;
  logic             done_c;

  logic [WORD_W-1:0] mem [NUM_OPORA];

  // Next-state, datapath updates and strobe decisions
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    csum_nxt     = csum;
    hi_nxt       = hi_byte;
    phase_nxt    = lo_phase;
    gap_nxt      = gap_cnt;
    pend_nxt     = drop_pend;
    err_code_nxt = err_code;
    err_c        = 1'b0;
    wr_c         = 1'b0;
    rd_c         = 1'b0;
    done_c       = 1'b0;

    // A frame arriving during a burst is refused and swallowed until its eof
    if ((state == S_PLAY || state == S_GAP) && rx_valid) begin
      if (rx_sof) begin
        err_c        = 1'b1;
        err_code_nxt = ERR_BUSY;
        pend_nxt     = ~rx_eof;
      end else if (rx_eof) begin
        pend_nxt = 1'b0;
      end
    end

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_sof) begin
          if (rx_data == CMD_OPORA) begin
            if (rx_eof) begin
              err_c        = 1'b1;
              err_code_nxt = ERR_SHORT;
            end else begin
              state_nxt = S_HDR;
            end
          end else if (!rx_eof) begin
            state_nxt = S_DROP;
          end
        end
      end

      S_HDR, S_DATA: begin
        if (rx_valid) begin
          if (rx_sof) begin
            err_c        = 1'b1;
            err_code_nxt = ERR_SHORT;
            state_nxt    = rx_eof ? S_IDLE : S_DROP;
          end else if (rx_eof) begin
            err_c        = 1'b1;
            err_code_nxt = ERR_SHORT;
            state_nxt    = S_IDLE;
          end else if (state == S_HDR) begin
            csum_nxt  = 8'd0;
            idx_nxt   = '0;
            phase_nxt = 1'b0;
            state_nxt = S_DATA;
          end else begin
            csum_nxt = csum ^ rx_data;
            if (!lo_phase) begin
              hi_nxt    = rx_data;
              phase_nxt = 1'b1;
            end else begin
              wr_c      = 1'b1;
              phase_nxt = 1'b0;
              idx_nxt   = idx + IDX_W'(1);
              if (idx == IDX_LAST) begin
                state_nxt = S_CSUM;
              end
            end
          end
        end
      end

      S_CSUM: begin
        if (rx_valid) begin
          if (rx_sof) begin
            err_c        = 1'b1;
            err_code_nxt = ERR_SHORT;
            state_nxt    = rx_eof ? S_IDLE : S_DROP;
          end else if (rx_eof) begin
            if (rx_data == csum) begin
              idx_nxt   = '0;
              pend_nxt  = 1'b0;
              state_nxt = S_PLAY;
            end else begin
              err_c        = 1'b1;
              err_code_nxt = ERR_CSUM;
              state_nxt    = S_IDLE;
            end
          end else begin
            err_c        = 1'b1;
            err_code_nxt = ERR_LONG;
            state_nxt    = S_DROP;
          end
        end
      end

      S_DROP: begin
        if (rx_valid && rx_eof) begin
          state_nxt = S_IDLE;
        end
      end

      S_PLAY: begin
        rd_c    = 1'b1;
        idx_nxt = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
          gap_nxt   = '0;
          state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        done_c  = (gap_cnt == '0);
        gap_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_END) begin
          state_nxt = pend_nxt ? S_DROP : S_IDLE;
          pend_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, parser registers and registered outputs
  always_ff @(posedge clke or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      csum      <= 8'd0;
      hi_byte   <= 8'd0;
      lo_phase  <= 1'b0;
      gap_cnt   <= '0;
      drop_pend <= 1'b0;
      opora_en  <= 1'b0;
      OPORA     <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_BUSY;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      csum      <= csum_nxt;
      hi_byte   <= hi_nxt;
      lo_phase  <= phase_nxt;
      gap_cnt   <= gap_nxt;
      drop_pend <= pend_nxt;
      opora_en  <= rd_c;
      busy      <= (state_nxt == S_PLAY) || (state_nxt == S_GAP);
      load_done <= done_c;
      load_err  <= err_c;
      err_code  <= err_code_nxt;
      if (rd_c) begin
        OPORA <= mem[idx];
      end
    end
  end

  // Word buffer write port; contents of rejected frames are never replayed
  always_ff @(posedge clke) begin
    if (wr_c) begin
      mem[idx] <= {hi_byte, rx_data};
    end
  end

endmodule

// File: tb/tb_opora_loader.sv
// Self-checking bench for opora_loader: directed frame scenarios with random
// byte gaps, checked against a frame-level outcome model.
module tb_opora_loader;

  localparam int unsigned NUM = 200;
  localparam logic [7:0]  CMD = 8'hA5;
  localparam int R_NONE = 4;
  localparam int R_GOOD = 5;

  logic        clke = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        opora_en;
  logic [15:0] OPORA;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  opora_loader dut (
    .clke      (clke),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .opora_en  (opora_en),
    .OPORA     (OPORA),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clke = ~clke;

  int cyc = 0;
  always @(posedge clke) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  frm[$];
  logic [7:0]  f1[$];
  logic [7:0]  f2[$];
  int          acc[$];
  logic [15:0] s_word[$];
  int          s_cyc[$];
  int          d_cyc[$];
  logic [1:0]  e_code[$];
  int          e_cyc[$];
  int          busy_first;
  int          busy_last;
  bit          busy_seen;

  // Output log, sampled on the inactive edge
  always @(negedge clke) begin
    if (opora_en === 1'b1) begin
      s_word.push_back(OPORA);
      s_cyc.push_back(cyc);
    end
    if (load_done === 1'b1) d_cyc.push_back(cyc);
    if (load_err === 1'b1) begin
      e_code.push_back(err_code);
      e_cyc.push_back(cyc);
    end
    if (busy === 1'b1) begin
      if (!busy_seen) busy_first = cyc;
      busy_last = cyc;
      busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    s_word.delete(); s_cyc.delete(); d_cyc.delete();
    e_code.delete(); e_cyc.delete();
    busy_seen = 1'b0; busy_first = -1; busy_last = -1;
  endtask

  task automatic build_frame(input bit counting, input logic [7:0] cmd);
    logic [7:0]  x;
    logic [15:0] wd;
    frm.delete();
    x = 8'd0;
    frm.push_back(cmd);
    frm.push_back(8'($urandom));
    for (int k = 0; k < NUM; k++) begin
      wd = counting ? 16'(k) : 16'($urandom);
      frm.push_back(wd[15:8]);
      frm.push_back(wd[7:0]);
      x = x ^ wd[15:8] ^ wd[7:0];
    end
    frm.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof, input int gaps);
    repeat (gaps) begin
      @(posedge clke); #1;
      rx_valid = 1'b0; rx_data = 8'($urandom);
      rx_sof = 1'($urandom); rx_eof = 1'($urandom);
    end
    @(posedge clke); #1;
    rx_valid = 1'b1; rx_data = b; rx_sof = sof; rx_eof = eof;
    acc.push_back(cyc);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_gap);
    acc.delete();
    foreach (f[i])
      send_byte(f[i], i == 0, i == f.size() - 1, (i == 0) ? 0 : $urandom_range(max_gap, 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clke); #1;
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    end
  endtask

  // Frame-level reference: outcome from length, command and XOR alone
  function automatic int classify(input logic [7:0] f[$], output int off);
    logic [7:0] x;
    int n;
    n   = f.size();
    off = n - 1;
    x   = 8'd0;
    if (f[0] != CMD) return R_NONE;
    if (n < 2 * NUM + 3) return 1;
    if (n > 2 * NUM + 3) begin
      off = 2 * NUM + 2;
      return 2;
    end
    for (int i = 2; i < 2 * NUM + 2; i++) x = x ^ f[i];
    return (x == f[2 * NUM + 2]) ? R_GOOD : 3;
  endfunction

  task automatic check_burst(input logic [7:0] f[$], input int t, input int base);
    chk("burst_present", 32'(s_word.size() >= base + NUM), 1);
    if (s_word.size() >= base + NUM) begin
      for (int k = 0; k < NUM; k++)
        chk($sformatf("word%0d", k), 32'(s_word[base + k]), 32'({f[2 + 2 * k], f[3 + 2 * k]}));
      chk("first_strobe_cycle", s_cyc[base], t + 2);
      chk("last_strobe_cycle", s_cyc[base + NUM - 1], t + 201);
    end
  endtask

  task automatic run_and_check(input logic [7:0] f[$], input int max_gap);
    int exp, off, t;
    exp = classify(f, off);
    clear_logs();
    send_frame(f, max_gap);
    idle(220);
    t = acc[acc.size() - 1];
    if (exp == R_GOOD) begin
      chk("strobe_count", s_word.size(), NUM);
      check_burst(f, t, 0);
      chk("done_count", d_cyc.size(), 1);
      if (d_cyc.size() > 0) chk("done_cycle", d_cyc[0], t + 202);
      chk("busy_first", busy_first, t + 1);
      chk("busy_last", busy_last, t + 203);
      chk("err_count", e_code.size(), 0);
    end else if (exp == R_NONE) begin
      chk("strobe_count", s_word.size(), 0);
      chk("done_count", d_cyc.size(), 0);
      chk("err_count", e_code.size(), 0);
    end else begin
      chk("strobe_count", s_word.size(), 0);
      chk("done_count", d_cyc.size(), 0);
      chk("err_count", e_code.size(), 1);
      if (e_code.size() > 0) begin
        chk("err_code", 32'(e_code[0]), exp);
        chk("err_cycle", e_cyc[0], acc[off] + 1);
      end
    end
  endtask

  initial begin
    int t1, t2, seen;
    rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    clear_logs();
    repeat (3) @(negedge clke);
    chk("rst_opora_en", opora_en, 0);
    chk("rst_OPORA", OPORA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_err_code", err_code, 0);
    @(posedge clke); #1 rst = 1'b0;
    idle(3);

    // Counting words, random valid gaps
    build_frame(1'b1, CMD); f1 = frm;
    run_and_check(f1, 3);
    // Checksum flipped
    f2 = f1; f2[2 * NUM + 2] = f2[2 * NUM + 2] ^ 8'h01;
    run_and_check(f2, 2);
    // eof at byte 100, then a good random frame
    f2 = f1; while (f2.size() > 100) void'(f2.pop_back());
    run_and_check(f2, 2);
    build_frame(1'b0, CMD); f1 = frm;
    run_and_check(f1, 2);
    // Missing checksum (402 bytes)
    f2 = f1; void'(f2.pop_back());
    run_and_check(f2, 1);
    // Foreign command
    build_frame(1'b0, 8'h11);
    run_and_check(frm, 2);
    // Extra byte after checksum
    build_frame(1'b0, CMD); f2 = frm; f2.push_back(8'h5A);
    run_and_check(f2, 2);
    // One-byte frames
    f2.delete(); f2.push_back(CMD);
    run_and_check(f2, 0);
    f2.delete(); f2.push_back(8'h33);
    run_and_check(f2, 0);

    // Good frame arriving during PLAY
    clear_logs();
    build_frame(1'b0, CMD); f1 = frm;
    send_frame(f1, 2);
    t1 = acc[acc.size() - 1];
    f2 = f1;
    for (int i = 2; i < 2 * NUM + 2; i++) f2[i] = 8'($urandom);
    send_frame(f2, 0);
    idle(220);
    chk("busy_strobe_count", s_word.size(), NUM);
    check_burst(f1, t1, 0);
    chk("busy_done_count", d_cyc.size(), 1);
    if (d_cyc.size() > 0) chk("busy_done_cycle", d_cyc[0], t1 + 202);
    chk("busy_err_count", e_code.size(), 1);
    if (e_code.size() > 0) begin
      chk("busy_err_code", 32'(e_code[0]), 0);
      chk("busy_err_cycle", e_cyc[0], t1 + 2);
    end

    // Two good frames, second sof at the earliest legal cycle
    clear_logs();
    build_frame(1'b0, CMD); f1 = frm;
    send_frame(f1, 2);
    t1 = acc[acc.size() - 1];
    idle(203);
    build_frame(1'b0, CMD); f2 = frm;
    send_frame(f2, 1);
    t2 = acc[acc.size() - 1];
    idle(220);
    chk("pair_strobe_count", s_word.size(), 2 * NUM);
    check_burst(f1, t1, 0);
    check_burst(f2, t2, NUM);
    chk("pair_done_count", d_cyc.size(), 2);
    if (s_cyc.size() >= NUM + 1) chk("pair_gap_ok", 32'(s_cyc[NUM] - s_cyc[NUM - 1] >= 3), 1);
    chk("pair_err_count", e_code.size(), 0);

    // Reset at strobe 50, then a full burst
    clear_logs();
    build_frame(1'b0, CMD);
    send_frame(frm, 2);
    idle(1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clke); #1;
      if (s_word.size() >= 50) seen = 1;
    end
    chk("reached_strobe50", seen, 1);
    rst = 1'b1;
    @(negedge clke);
    chk("mid_rst_opora_en", opora_en, 0);
    chk("mid_rst_OPORA", OPORA, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_load_done", load_done, 0);
    chk("mid_rst_load_err", load_err, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_strobes", s_word.size(), 50);
    @(posedge clke); #1 rst = 1'b0;
    idle(2);
    build_frame(1'b0, CMD); f1 = frm;
    run_and_check(f1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
